// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: turns received UART command bytes into counter controls (run, clear, mode).
// Define UART_CMD_ECHO_EN to add the 3-byte acknowledgment sequencer and one-deep pending slot.
module uart_cmd_ctrl #(
  parameter logic [7:0] CMD_RUN      = 8'h72,
  parameter logic [7:0] CMD_CLEAR    = 8'h63,
  parameter logic [7:0] CMD_MODE     = 8'h6D,
  parameter int         CASE_INSENS  = 1,
  parameter int         BUSY_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] i_rx_data,
  input  logic       i_rx_done,
  input  logic       i_tx_busy,
  output logic       o_tx_start,
  output logic [7:0] o_tx_data,
  output logic       o_enable,
  output logic       o_clear,
  output logic       o_mode,
  output logic       o_err,
  output logic       o_overrun
);

  localparam logic [7:0] UPPER_OFS = 8'h20;

  logic isRun, isClear, isMode, isValid;
  logic accept, timeoutErr;
  logic enable_q, enable_d, mode_q, mode_d, clear_q, clear_d;
  logic err_q, err_d, overrun_q, overrun_d;

  always_comb begin
    isRun   = (i_rx_data == CMD_RUN)   || ((CASE_INSENS != 0) && (i_rx_data == (CMD_RUN - UPPER_OFS)));
    isClear = (i_rx_data == CMD_CLEAR) || ((CASE_INSENS != 0) && (i_rx_data == (CMD_CLEAR - UPPER_OFS)));
    isMode  = (i_rx_data == CMD_MODE)  || ((CASE_INSENS != 0) && (i_rx_data == (CMD_MODE - UPPER_OFS)));
    isValid = isRun || isClear || isMode;
  end

  always_comb begin
    enable_d  = enable_q ^ (accept && isRun);
    mode_d    = mode_q ^ (accept && isMode);
    clear_d   = accept && isClear;
    err_d     = (accept && !isValid) || timeoutErr;
    overrun_d = i_rx_done && !accept;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      enable_q  <= 1'b0;
      mode_q    <= 1'b0;
      clear_q   <= 1'b0;
      err_q     <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      enable_q  <= enable_d;
      mode_q    <= mode_d;
      clear_q   <= clear_d;
      err_q     <= err_d;
      overrun_q <= overrun_d;
    end
  end

  assign o_enable  = enable_q;
  assign o_mode    = mode_q;
  assign o_clear   = clear_q;
  assign o_err     = err_q;
  assign o_overrun = overrun_q;

`ifdef UART_CMD_ECHO_EN
  localparam int               CNT_W      = $clog2(BUSY_TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(BUSY_TIMEOUT - 2);
  localparam logic [7:0]       CHAR_QMARK = 8'h3F;
  localparam logic [7:0]       CHAR_CR    = 8'h0D;
  localparam logic [7:0]       CHAR_LF    = 8'h0A;

  typedef enum logic [2:0] {IDLE, START, WAIT_HI, WAIT_LO, NEXT} state_t;

  state_t           state_q, state_d;
  logic             slotFull_q, slotFull_d;
  logic [7:0]       slotByte_q, slotByte_d;
  logic [7:0]       head_q, head_d;
  logic [1:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             slotTake;
  logic [7:0]       curByte;

  // A full slot being drained this cycle can be refilled in the same cycle.
  assign slotTake = (state_q == IDLE) && slotFull_q;
  assign accept   = i_rx_done && (!slotFull_q || slotTake);

  always_comb begin
    slotFull_d = (slotFull_q && !slotTake) || accept;
    slotByte_d = slotByte_q;
    if (accept) begin
      slotByte_d = isValid ? i_rx_data : CHAR_QMARK;
    end
  end

  always_comb begin
    unique case (idx_q)
      2'd0:    curByte = head_q;
      2'd1:    curByte = CHAR_CR;
      default: curByte = CHAR_LF;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    head_d     = head_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    timeoutErr = 1'b0;
    o_tx_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (slotFull_q) begin
          head_d  = slotByte_q;
          idx_d   = 2'd0;
          state_d = START;
        end
      end
      START: begin
        if (!i_tx_busy) begin
          o_tx_start = 1'b1;
          cnt_d      = '0;
          state_d    = WAIT_HI;
        end
      end
      WAIT_HI: begin
        if (i_tx_busy) begin
          state_d = WAIT_LO;
        end else if (cnt_q == CNT_LAST) begin
          // Error pulse lands BUSY_TIMEOUT cycles after the start pulse.
          timeoutErr = 1'b1;
          state_d    = NEXT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT_LO: begin
        if (!i_tx_busy) begin
          state_d = NEXT;
        end
      end
      NEXT: begin
        if (idx_q == 2'd2) begin
          state_d = IDLE;
        end else begin
          idx_d   = idx_q + 2'd1;
          state_d = START;
        end
      end
      default: state_d = IDLE;
    endcase
    if (rst) begin
      o_tx_start = 1'b0;
    end
  end

  assign o_tx_data = ((state_q == IDLE) || rst) ? 8'h00 : curByte;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      slotFull_q <= 1'b0;
      slotByte_q <= 8'h00;
      head_q     <= 8'h00;
      idx_q      <= 2'd0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      slotFull_q <= slotFull_d;
      slotByte_q <= slotByte_d;
      head_q     <= head_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
    end
  end
`else
  logic unusedInputs;

  assign accept       = i_rx_done;
  assign timeoutErr   = 1'b0;
  assign o_tx_start   = 1'b0;
  assign o_tx_data    = 8'h00;
  assign unusedInputs = i_tx_busy ^ (BUSY_TIMEOUT < 2);
`endif

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Self-checking bench for uart_cmd_ctrl: reset, a directed vector table, randomized
// commands against a behavioural model and, with UART_CMD_ECHO_EN, the TX response corner cases.
module tb_uart_cmd_ctrl;

  localparam logic [7:0] CMD_RUN      = 8'h72;
  localparam logic [7:0] CMD_CLEAR    = 8'h63;
  localparam logic [7:0] CMD_MODE     = 8'h6D;
  localparam int         CASE_INSENS  = 1;
  localparam int         BUSY_TIMEOUT = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rxData;
  logic       rxDone;
  logic       txBusy;
  logic       txStart;
  logic [7:0] txData;
  logic       enable, clear, mode, err, overrun;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Behavioural model state: control levels follow the count of accepted toggle commands.
  bit mEnable = 1'b0;
  bit mMode   = 1'b0;

  logic [7:0] sentQ[$];
  logic [7:0] expQ[$];
  int         startCyc[$];
  int         errCyc[$];
  int         busyLen   = 3;
  bit         busyNever = 1'b0;

  typedef struct {
    logic [7:0] data;
    bit         done;
    bit         expEnable;
    bit         expClear;
    bit         expMode;
    bit         expErr;
  } vec_t;

  vec_t tbl[14];

  uart_cmd_ctrl #(
    .CMD_RUN(CMD_RUN), .CMD_CLEAR(CMD_CLEAR), .CMD_MODE(CMD_MODE),
    .CASE_INSENS(CASE_INSENS), .BUSY_TIMEOUT(BUSY_TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .i_rx_data(rxData), .i_rx_done(rxDone), .i_tx_busy(txBusy),
    .o_tx_start(txStart), .o_tx_data(txData), .o_enable(enable), .o_clear(clear),
    .o_mode(mode), .o_err(err), .o_overrun(overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: record every transmitted byte and every error pulse with its cycle number.
  always @(negedge clk) begin
    if (txStart === 1'b1) begin
      sentQ.push_back(txData);
      startCyc.push_back(cyc);
    end
    if (err === 1'b1) errCyc.push_back(cyc);
  end

  // UART TX model: busy rises the cycle after a start pulse and stays high busyLen cycles.
  initial begin
    txBusy = 1'b0;
    forever begin
      @(negedge clk);
      if (txStart === 1'b1 && !busyNever) begin
        @(posedge clk);
        #2 txBusy = 1'b1;
        repeat (busyLen) @(posedge clk);
        #2 txBusy = 1'b0;
      end
    end
  end

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic bit isCmd(input logic [7:0] b, input logic [7:0] c);
    logic [7:0] upper;
    upper = c - 8'h20;
    return (b == c) || ((CASE_INSENS != 0) && (b == upper));
  endfunction

  function automatic bit isValidCmd(input logic [7:0] b);
    return isCmd(b, CMD_RUN) || isCmd(b, CMD_CLEAR) || isCmd(b, CMD_MODE);
  endfunction

  function automatic logic [7:0] pickByte();
    case ($urandom_range(0, 9))
      0: return 8'h72;
      1: return 8'h52;
      2: return 8'h63;
      3: return 8'h43;
      4: return 8'h6D;
      5: return 8'h4D;
      6: return 8'h92;
      7: return 8'h3F;
      default: return 8'($urandom);
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Drives one byte for one cycle (cycle N) and returns #1 after the edge into N+1.
  task automatic applyStimulus(input logic [7:0] b, input bit d);
    rxData = b;
    rxDone = d;
    @(posedge clk);
    #1;
    rxDone = 1'b0;
  endtask

  // Model update for an accepted byte; returns the expected one-cycle pulses.
  task automatic modelAccept(input logic [7:0] b, output bit eClr, output bit eErr);
    if (isCmd(b, CMD_RUN))  mEnable = ~mEnable;
    if (isCmd(b, CMD_MODE)) mMode   = ~mMode;
    eClr = isCmd(b, CMD_CLEAR);
    eErr = !isValidCmd(b);
  endtask

  task automatic checkCycle(input string tag, input bit eClr, input bit eErr, input bit eOvr);
    checkOutput({tag, ".enable"},  enable,  mEnable);
    checkOutput({tag, ".mode"},    mode,    mMode);
    checkOutput({tag, ".clear"},   clear,   eClr);
    checkOutput({tag, ".err"},     err,     eErr);
    checkOutput({tag, ".overrun"}, overrun, eOvr);
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

`ifdef UART_CMD_ECHO_EN
  // Waits (bounded) for every expected response byte, lets the line settle, then compares in order.
  task automatic checkResponses(input int settle);
    int guard = 0;
    while (sentQ.size() < expQ.size() && guard < 2000) begin
      idleCycles(1);
      guard++;
    end
    idleCycles(settle);
    checkOutput("txCount", sentQ.size(), expQ.size());
    for (int k = 0; k < expQ.size() && k < sentQ.size(); k++)
      checkOutput($sformatf("txByte%0d", k), sentQ[k], expQ[k]);
    sentQ.delete();
    expQ.delete();
  endtask

  task automatic expectResponse(input logic [7:0] b);
    expQ.push_back(isValidCmd(b) ? b : 8'h3F);
    expQ.push_back(8'h0D);
    expQ.push_back(8'h0A);
  endtask
`endif

  initial begin
    bit         eClr, eErr, d;
    logic [7:0] b;
    int         guard;

    rst    = 1'b1;
    rxData = 8'h00;
    rxDone = 1'b0;

    tbl[0]  = '{8'h72, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{8'h72, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{8'h52, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{8'h63, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{8'h43, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{8'h6D, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[6]  = '{8'h4D, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{8'h78, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[8]  = '{8'h72, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{8'h3F, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[10] = '{8'h92, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[11] = '{8'h6D, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[12] = '{8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[13] = '{8'h72, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

    // Reset held for three cycles, then released.
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("rst.txStart", txStart, 1'b0);
    checkOutput("rst.txData",  txData,  8'h00);
    checkCycle("rst", 1'b0, 1'b0, 1'b0);
    sentQ.delete();
    idleCycles(100);
    checkOutput("rst.idleStarts", sentQ.size(), 0);
    checkOutput("rst.idleEnable", enable, 1'b0);

    // Directed vector table; back-to-back in the plain build.
    for (int i = 0; i < 14; i++) begin
      applyStimulus(tbl[i].data, tbl[i].done);
      checkOutput($sformatf("tbl%0d.enable", i),  enable,  tbl[i].expEnable);
      checkOutput($sformatf("tbl%0d.clear", i),   clear,   tbl[i].expClear);
      checkOutput($sformatf("tbl%0d.mode", i),    mode,    tbl[i].expMode);
      checkOutput($sformatf("tbl%0d.err", i),     err,     tbl[i].expErr);
      checkOutput($sformatf("tbl%0d.overrun", i), overrun, 1'b0);
      checkOutput($sformatf("tbl%0d.txStart", i), txStart, 1'b0);
`ifdef UART_CMD_ECHO_EN
      if (tbl[i].done) begin
        expQ.push_back(tbl[i].expErr ? 8'h3F : tbl[i].data);
        expQ.push_back(8'h0D);
        expQ.push_back(8'h0A);
        checkResponses(busyLen + 8);
      end
`endif
    end
    mEnable = tbl[13].expEnable;
    mMode   = tbl[13].expMode;

    // Randomized commands against the behavioural model.
    for (int i = 0; i < 200; i++) begin
      b = pickByte();
      d = 1'($urandom_range(0, 1));
      applyStimulus(b, d);
      eClr = 1'b0;
      eErr = 1'b0;
      if (d) modelAccept(b, eClr, eErr);
      checkCycle($sformatf("rand%0d", i), eClr, eErr, 1'b0);
      checkOutput($sformatf("rand%0d.txStart", i), txStart, 1'b0);
`ifdef UART_CMD_ECHO_EN
      if (d) begin
        expectResponse(b);
        checkResponses(busyLen + 8);
      end
`endif
    end

`ifdef UART_CMD_ECHO_EN
    // Queue one command behind an active response and drop the next one.
    busyLen = 4;
    applyStimulus(CMD_RUN, 1'b1);
    modelAccept(CMD_RUN, eClr, eErr);
    checkCycle("q.first", eClr, eErr, 1'b0);
    expectResponse(CMD_RUN);
    guard = 0;
    while (!(sentQ.size() >= 1 && txBusy === 1'b1) && guard < 100) begin
      idleCycles(1);
      guard++;
    end
    checkOutput("q.busyWait", guard < 100, 1'b1);
    applyStimulus(CMD_MODE, 1'b1);
    modelAccept(CMD_MODE, eClr, eErr);
    checkCycle("q.queued", eClr, eErr, 1'b0);
    expectResponse(CMD_MODE);
    applyStimulus(CMD_RUN, 1'b1);
    checkCycle("q.dropped", 1'b0, 1'b0, 1'b1);
    checkResponses(busyLen + 8);

    // Busy never rises: each byte times out with an error pulse.
    busyNever = 1'b1;
    startCyc.delete();
    errCyc.delete();
    applyStimulus(CMD_CLEAR, 1'b1);
    modelAccept(CMD_CLEAR, eClr, eErr);
    checkCycle("to.cmd", eClr, eErr, 1'b0);
    expectResponse(CMD_CLEAR);
    checkResponses(40);
    checkOutput("to.starts", startCyc.size(), 3);
    checkOutput("to.errs", errCyc.size(), 3);
    for (int k = 0; k < 3 && k < startCyc.size() && k < errCyc.size(); k++)
      checkOutput($sformatf("to.delay%0d", k), errCyc[k] - startCyc[k], BUSY_TIMEOUT);
    busyNever = 1'b0;

    // Reset in the middle of the second response byte.
    busyLen = 6;
    applyStimulus(CMD_RUN, 1'b1);
    modelAccept(CMD_RUN, eClr, eErr);
    checkCycle("mid.cmd", eClr, eErr, 1'b0);
    guard = 0;
    while (!(sentQ.size() >= 2 && txBusy === 1'b1) && guard < 100) begin
      idleCycles(1);
      guard++;
    end
    checkOutput("mid.busyWait", guard < 100, 1'b1);
    idleCycles(1);
    rst = 1'b1;
    idleCycles(1);
    checkOutput("mid.txStart", txStart, 1'b0);
    checkOutput("mid.txData", txData, 8'h00);
    mEnable = 1'b0;
    mMode   = 1'b0;
    checkCycle("mid.rst", 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    sentQ.delete();
    expQ.delete();
    idleCycles(30);
    checkOutput("mid.noStart", sentQ.size(), 0);
    applyStimulus(CMD_MODE, 1'b1);
    modelAccept(CMD_MODE, eClr, eErr);
    checkCycle("mid.after", eClr, eErr, 1'b0);
    expectResponse(CMD_MODE);
    checkResponses(busyLen + 8);
`else
    // Without the sequencer, busy activity must not matter and nothing is transmitted.
    sentQ.delete();
    for (int i = 0; i < 20; i++) begin
      txBusy = 1'($urandom_range(0, 1));
      applyStimulus(CMD_MODE, 1'b1);
      modelAccept(CMD_MODE, eClr, eErr);
      checkCycle($sformatf("busy%0d", i), eClr, eErr, 1'b0);
    end
    checkOutput("busy.noStart", sentQ.size(), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
